// File: rtl/seq_pkg.sv
// Shared definitions for the sequencer-stream monitor: lock FSM encoding,
// derived result widths and the frame signature packing order.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    // Sum width: a full frame of maximum samples can never overflow.
    function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned frame_len);
        return data_w + $clog2(frame_len);
    endfunction

    // Repeat-count width: a frame has at most frame_len-1 repeat pairs.
    function automatic int unsigned rc_width(input int unsigned frame_len);
        return $clog2(frame_len);
    endfunction

    // Signature is packed {min, max, sum, rep}, rep in the least significant bits.
    function automatic int unsigned sig_width(input int unsigned data_w, input int unsigned frame_len);
        return 2 * data_w + sum_width(data_w, frame_len) + rc_width(frame_len);
    endfunction

    function automatic int unsigned sig_rep_lsb();
        return 0;
    endfunction

    function automatic int unsigned sig_sum_lsb(input int unsigned frame_len);
        return rc_width(frame_len);
    endfunction

    function automatic int unsigned sig_max_lsb(input int unsigned data_w, input int unsigned frame_len);
        return rc_width(frame_len) + sum_width(data_w, frame_len);
    endfunction

    function automatic int unsigned sig_min_lsb(input int unsigned data_w, input int unsigned frame_len);
        return rc_width(frame_len) + sum_width(data_w, frame_len) + data_w;
    endfunction

endpackage

// File: rtl/frame_accum.sv
// Frame accumulator: tracks the sample index and running min/max/sum/repeat
// statistics, and presents the finished signature on the last sample.
module frame_accum
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 5,
    localparam int unsigned SUM_W    = sum_width(DATA_W, FRAME_LEN),
    localparam int unsigned RC_W     = rc_width(FRAME_LEN),
    localparam int unsigned SIG_W    = sig_width(DATA_W, FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              frame_end_c,
    output logic [SIG_W-1:0]  sig_c
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] acc_min;
    logic [DATA_W-1:0] acc_max;
    logic [SUM_W-1:0]  acc_sum;
    logic [RC_W-1:0]   acc_rep;
    logic [DATA_W-1:0] prev;

    logic              first;
    logic              is_rep;
    logic [DATA_W-1:0] nxt_min;
    logic [DATA_W-1:0] nxt_max;
    logic [SUM_W-1:0]  nxt_sum;
    logic [RC_W-1:0]   nxt_rep;

    // Statistics including the current sample; the first sample of a frame reloads them.
    always_comb begin
        first   = (idx == '0);
        is_rep  = !first && (in_data == prev);
        nxt_min = acc_min;
        nxt_max = acc_max;
        nxt_sum = acc_sum;
        nxt_rep = acc_rep;
        if (first) begin
            nxt_min = in_data;
            nxt_max = in_data;
            nxt_sum = SUM_W'(in_data);
            nxt_rep = '0;
        end else begin
            nxt_min = (in_data < acc_min) ? in_data : acc_min;
            nxt_max = (in_data > acc_max) ? in_data : acc_max;
            nxt_sum = acc_sum + SUM_W'(in_data);
            nxt_rep = acc_rep + RC_W'(is_rep);
        end
        frame_end_c = in_valid && !clear && (idx == IDX_LAST);
        sig_c       = {nxt_min, nxt_max, nxt_sum, nxt_rep};
    end

    // Index and accumulator registers; clear beats a same-cycle sample.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx     <= '0;
            acc_min <= '0;
            acc_max <= '0;
            acc_sum <= '0;
            acc_rep <= '0;
            prev    <= '0;
        end else if (in_valid) begin
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            acc_min <= nxt_min;
            acc_max <= nxt_max;
            acc_sum <= nxt_sum;
            acc_rep <= nxt_rep;
            prev    <= in_data;
        end
    end

endmodule

// File: rtl/seq_monitor.sv
// Sequencer stream monitor: per-frame statistics and signature-based lock detection.
module seq_monitor
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FRAME_LEN   = 5,
    parameter int unsigned LOCK_FRAMES = 2,
    localparam int unsigned SUM_W      = sum_width(DATA_W, FRAME_LEN),
    localparam int unsigned RC_W       = rc_width(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val,
    output logic [SUM_W-1:0]  sum_val,
    output logic [RC_W-1:0]   rep_cnt,
    output logic              frame_done,
    output logic              locked,
    output logic              lock_lost
);

    localparam int unsigned SIG_W   = sig_width(DATA_W, FRAME_LEN);
    localparam int unsigned MC_W    = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned REP_LSB = sig_rep_lsb();
    localparam int unsigned SUM_LSB = sig_sum_lsb(FRAME_LEN);
    localparam int unsigned MAX_LSB = sig_max_lsb(DATA_W, FRAME_LEN);
    localparam int unsigned MIN_LSB = sig_min_lsb(DATA_W, FRAME_LEN);

    logic             frame_end_c;
    logic [SIG_W-1:0] sig_c;

    lock_state_e      state_q, state_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [SIG_W-1:0] ref_q, ref_d;
    logic             lost_d;
    logic [MC_W-1:0]  match_inc;

    frame_accum #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .frame_end_c (frame_end_c),
        .sig_c       (sig_c)
    );

    // Lock FSM next-state: compares each finished frame's signature with the reference.
    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        ref_d     = ref_q;
        lost_d    = 1'b0;
        match_inc = match_q + MC_W'(1);
        if (clear) begin
            state_d = ST_IDLE;
            match_d = '0;
        end else if (frame_end_c) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    ref_d   = sig_c;
                    match_d = '0;
                end
                ST_ACQUIRE: begin
                    if (sig_c == ref_q) begin
                        match_d = match_inc;
                        if (match_inc >= MC_W'(LOCK_FRAMES)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        ref_d   = sig_c;
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (sig_c != ref_q) begin
                        state_d = ST_ACQUIRE;
                        ref_d   = sig_c;
                        match_d = '0;
                        lost_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    match_d = '0;
                end
            endcase
        end
    end

    // Lock FSM state and reference signature.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            match_q <= '0;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            ref_q   <= ref_d;
        end
    end

    // Result and status registers; results hold across clear and update only on frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_val    <= '0;
            max_val    <= '0;
            sum_val    <= '0;
            rep_cnt    <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            frame_done <= frame_end_c;
            lock_lost  <= lost_d;
            locked     <= (state_d == ST_LOCKED);
            if (frame_end_c) begin
                min_val <= sig_c[MIN_LSB +: DATA_W];
                max_val <= sig_c[MAX_LSB +: DATA_W];
                sum_val <= sig_c[SUM_LSB +: SUM_W];
                rep_cnt <= sig_c[REP_LSB +: RC_W];
            end
        end
    end

endmodule

// File: tb/tb_seq_monitor.sv
// Self-checking bench for seq_monitor: directed vector table, hand-written
// corner sequences and a randomized run against a frame-level reference model.
module tb_seq_monitor;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned FRAME_LEN   = 5;
    localparam int unsigned LOCK_FRAMES = 2;
    localparam int unsigned SUM_W       = DATA_W + $clog2(FRAME_LEN);
    localparam int unsigned RC_W        = $clog2(FRAME_LEN);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] min_val;
    logic [DATA_W-1:0] max_val;
    logic [SUM_W-1:0]  sum_val;
    logic [RC_W-1:0]   rep_cnt;
    logic              frame_done;
    logic              locked;
    logic              lock_lost;

    int checks = 0;
    int failures = 0;

    seq_monitor #(
        .DATA_W      (DATA_W),
        .FRAME_LEN   (FRAME_LEN),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clear      (clear),
        .min_val    (min_val),
        .max_val    (max_val),
        .sum_val    (sum_val),
        .rep_cnt    (rep_cnt),
        .frame_done (frame_done),
        .locked     (locked),
        .lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    // Reference model: collects a frame's samples, evaluates it at completion.
    int     m_frame[$];
    int     m_min, m_max, m_sum, m_rep;
    bit     m_done, m_locked, m_lost;
    bit     m_active;
    int     m_cnt;
    longint m_ref;

    task automatic model_reset();
        m_frame.delete();
        m_min = 0; m_max = 0; m_sum = 0; m_rep = 0;
        m_done = 0; m_locked = 0; m_lost = 0;
        m_active = 0; m_cnt = 0; m_ref = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c);
        longint sig;
        m_done = 0;
        m_lost = 0;
        if (c) begin
            m_frame.delete();
            m_active = 0;
            m_cnt = 0;
            m_locked = 0;
        end else if (v) begin
            m_frame.push_back(d);
            if (m_frame.size() == FRAME_LEN) begin
                m_min = m_frame[0]; m_max = m_frame[0]; m_sum = 0; m_rep = 0;
                foreach (m_frame[i]) begin
                    if (m_frame[i] < m_min) m_min = m_frame[i];
                    if (m_frame[i] > m_max) m_max = m_frame[i];
                    m_sum += m_frame[i];
                    if (i > 0 && m_frame[i] == m_frame[i-1]) m_rep++;
                end
                m_frame.delete();
                m_done = 1;
                sig = (longint'(m_min) << 40) | (longint'(m_max) << 24) | (longint'(m_sum) << 8) | longint'(m_rep);
                if (!m_active) begin
                    m_active = 1; m_ref = sig; m_cnt = 0;
                end else if (sig == m_ref) begin
                    if (!m_locked) begin
                        m_cnt++;
                        if (m_cnt >= LOCK_FRAMES) m_locked = 1;
                    end
                end else begin
                    if (m_locked) m_lost = 1;
                    m_locked = 0; m_ref = sig; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("min_val", int'(min_val), m_min);
        chk("max_val", int'(max_val), m_max);
        chk("sum_val", int'(sum_val), m_sum);
        chk("rep_cnt", int'(rep_cnt), m_rep);
        chk("frame_done", int'(frame_done), int'(m_done));
        chk("locked", int'(locked), int'(m_locked));
        chk("lock_lost", int'(lock_lost), int'(m_lost));
    endtask

    // One clock: drive inputs, advance model with the same inputs, compare after the edge.
    task automatic step(input bit v, input int d, input bit c);
        in_valid = v;
        in_data  = DATA_W'(d);
        clear    = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        compare_model();
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        compare_model();
        rst = 1'b0;
    endtask

    task automatic send_frame(input int s0, input int s1, input int s2, input int s3, input int s4);
        int f[5];
        f = '{s0, s1, s2, s3, s4};
        for (int i = 0; i < 5; i++) step(1'b1, f[i], 1'b0);
    endtask

    typedef struct {
        bit  v;
        int  d;
        bit  exp_done;
        bit  exp_locked;
        int  exp_min;
        int  exp_max;
        int  exp_sum;
        int  exp_rep;
    } vec_t;

    int pat[5];
    vec_t tbl[15];
    int done_cnt;

    initial begin
        pat = '{13, 15, 17, 17, 45};
        // Continuous stream after reset: three frames, lock at the end of frame 3.
        for (int i = 0; i < 15; i++) begin
            tbl[i].v          = 1'b1;
            tbl[i].d          = pat[i % 5];
            tbl[i].exp_done   = (i % 5 == 4);
            tbl[i].exp_locked = (i >= 14);
            tbl[i].exp_min    = (i >= 4) ? 13  : 0;
            tbl[i].exp_max    = (i >= 4) ? 45  : 0;
            tbl[i].exp_sum    = (i >= 4) ? 107 : 0;
            tbl[i].exp_rep    = (i >= 4) ? 1   : 0;
        end

        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();
        chk("reset_sum", int'(sum_val), 0);
        chk("reset_locked", int'(locked), 0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].d, 1'b0);
            chk("tbl_done", int'(frame_done), int'(tbl[i].exp_done));
            chk("tbl_locked", int'(locked), int'(tbl[i].exp_locked));
            chk("tbl_min", int'(min_val), tbl[i].exp_min);
            chk("tbl_max", int'(max_val), tbl[i].exp_max);
            chk("tbl_sum", int'(sum_val), tbl[i].exp_sum);
            chk("tbl_rep", int'(rep_cnt), tbl[i].exp_rep);
        end

        // Mismatching frame while locked.
        send_frame(13, 15, 17, 18, 45);
        chk("lost_pulse", int'(lock_lost), 1);
        chk("lost_locked", int'(locked), 0);
        chk("lost_sum", int'(sum_val), 108);
        chk("lost_rep", int'(rep_cnt), 0);
        step(1'b0, 0, 1'b0);
        chk("lost_pulse_end", int'(lock_lost), 0);
        send_frame(13, 15, 17, 17, 45);
        send_frame(13, 15, 17, 17, 45);
        chk("relock_early", int'(locked), 0);
        send_frame(13, 15, 17, 17, 45);
        chk("relock", int'(locked), 1);

        // Width/overflow corner and maximal repeat count.
        send_frame(0, 255, 255, 255, 255);
        chk("wide_min", int'(min_val), 0);
        chk("wide_max", int'(max_val), 255);
        chk("wide_sum", int'(sum_val), 1020);
        chk("wide_rep", int'(rep_cnt), 3);
        send_frame(7, 7, 7, 7, 7);
        chk("rep4", int'(rep_cnt), 4);
        chk("rep4_sum", int'(sum_val), 35);

        // Gapped stream from reset: frame_done every 10 cycles, lock at frame 3.
        do_reset();
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, pat[i % 5], 1'b0);
            if (frame_done) done_cnt++;
            step(1'b0, 99, 1'b0);
        end
        chk("gap_frames", done_cnt, 3);
        chk("gap_locked", int'(locked), 1);
        chk("gap_sum", int'(sum_val), 107);

        // Clear with a sample mid-frame on a locked stream.
        step(1'b1, 13, 1'b0);
        step(1'b1, 15, 1'b0);
        step(1'b1, 17, 1'b0);
        step(1'b1, 17, 1'b1);
        chk("clr_locked", int'(locked), 0);
        chk("clr_lost", int'(lock_lost), 0);
        chk("clr_hold_sum", int'(sum_val), 107);
        for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0);
        chk("clr_no_early_done", int'(frame_done), 0);
        step(1'b1, pat[4], 1'b0);
        chk("clr_fresh_done", int'(frame_done), 1);
        chk("clr_fresh_locked", int'(locked), 0);

        // Reset mid-frame.
        step(1'b1, 13, 1'b0);
        step(1'b1, 15, 1'b0);
        do_reset();
        chk("rst_sum", int'(sum_val), 0);
        chk("rst_min", int'(min_val), 0);
        for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0);
        chk("rst_no_early_done", int'(frame_done), 0);
        step(1'b1, pat[4], 1'b0);
        chk("rst_first_done", int'(frame_done), 1);

        // Randomized stream: mostly the periodic pattern, with corruption, gaps, clears, resets.
        for (int n = 0; n < 4000; n++) begin
            int r;
            int d;
            bit v;
            bit c;
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                do_reset();
            end else begin
                v = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 29) == 0) d = int'($urandom_range(0, 255));
                else d = pat[m_frame.size()];
                step(v, d, c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
